bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It generalises our fixed 4-bit-to-two-digit combinational decoder to any input width and digit count. It sits between arithmetic datapaths and the seven-segment display drivers. A start/busy/done handshake lets one instance be time-shared across several sources.

---
 rtl/bin_to_bcd_seq.sv | 89 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter, one bit per clock
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [WIDTH-1:0]  bin_sr;
  logic [BW-1:0]     scratch;
  logic [BW-1:0]     scratch_adj;
  logic [BW-1:0]     scratch_nxt;
  logic              sticky;
  logic              sticky_nxt;
  logic [CW-1:0]     cnt;

  // Add 3 to every scratch digit of 5 or more so the following shift carries correctly
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift next binary bit into the units digit; the bit leaving the top digit marks overflow
  always_comb begin
    scratch_nxt = {scratch_adj[BW-2:0], bin_sr[WIDTH-1]};
    sticky_nxt  = sticky | scratch_adj[BW-1];
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      sticky  <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin;
            scratch <= '0;
            sticky  <= 1'b0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr  <= bin_sr << 1;
          scratch <= scratch_nxt;
          sticky  <= sticky_nxt;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd   <= scratch_nxt;
            ovf   <= sticky_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench for bin_to_bcd_seq at three parameter sets
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // dut0: 8 bits, 3 digits
  logic        start0 = 1'b0;
  logic [7:0]  bin0 = '0;
  logic        busy0, done0, ovf0;
  logic [11:0] bcd0;
  // dut1: 8 bits, 2 digits
  logic        start1 = 1'b0;
  logic [7:0]  bin1 = '0;
  logic        busy1, done1, ovf1;
  logic [7:0]  bcd1;
  // dut2: 16 bits, 5 digits
  logic        start2 = 1'b0;
  logic [15:0] bin2 = '0;
  logic        busy2, done2, ovf2;
  logic [19:0] bcd2;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bin(bin0),
    .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2));

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   dones0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [19:0] dec_model(input int v, input int digits);
    logic [19:0] r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Monitors: pop the expected result whenever a DUT pulses done
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      dones0++;
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", {20'd0, bcd0}, 32'hffff_ffff);
      end else begin
        e = q0.pop_front();
        chk("dut0_bcd", {20'd0, bcd0}, {12'd0, e.bcd});
        chk("dut0_ovf", {31'd0, ovf0}, {31'd0, e.ovf});
        chk("dut0_latency", cyc - e.acc, 32'd8);
        chk("dut0_busy_at_done", {31'd0, busy0}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", {24'd0, bcd1}, 32'hffff_ffff);
      end else begin
        e = q1.pop_front();
        chk("dut1_bcd", {24'd0, bcd1}, {12'd0, e.bcd});
        chk("dut1_ovf", {31'd0, ovf1}, {31'd0, e.ovf});
        chk("dut1_latency", cyc - e.acc, 32'd8);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_done", {12'd0, bcd2}, 32'hffff_ffff);
      end else begin
        e = q2.pop_front();
        chk("dut2_bcd", {12'd0, bcd2}, {12'd0, e.bcd});
        chk("dut2_ovf", {31'd0, ovf2}, {31'd0, e.ovf});
        chk("dut2_latency", cyc - e.acc, 32'd16);
      end
    end
  end

  // Issue one request to an idle DUT and record its expected result
  task automatic issue(input int d, input logic [15:0] v, input logic [19:0] eb, input logic eo);
    exp_t e;
    @(negedge clk);
    e.bcd = eb;
    e.ovf = eo;
    e.acc = cyc + 1;
    case (d)
      0: begin start0 = 1'b1; bin0 = v[7:0]; q0.push_back(e); end
      1: begin start1 = 1'b1; bin1 = v[7:0]; q1.push_back(e); end
      default: begin start2 = 1'b1; bin2 = v; q2.push_back(e); end
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic drain(input int d);
    int t = 0;
    while (qsize(d) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", qsize(d), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   t;
    int   base;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_done", {31'd0, done0}, 32'd0);
    chk("reset_bcd",  {20'd0, bcd0},  32'd0);
    chk("reset_ovf",  {31'd0, ovf0},  32'd0);

    // Directed vectors, 8 bits / 3 digits
    issue(0, 16'd255, 20'h255, 1'b0);
    chk("busy_after_accept", {31'd0, busy0}, 32'd1);
    drain(0);
    issue(0, 16'd0,  20'h000, 1'b0); drain(0);
    issue(0, 16'd10, 20'h010, 1'b0); drain(0);
    issue(0, 16'd9,  20'h009, 1'b0); drain(0);

    // Back-to-back sweep, restarting in every done cycle
    base = dones0;
    @(negedge clk);
    e.bcd = dec_model(0, 3); e.ovf = 1'b0; e.acc = cyc + 1;
    start0 = 1'b1; bin0 = 8'd0; q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    for (int v = 1; v < 256; v++) begin
      t = 0;
      while (!done0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!done0) begin
        chk("sweep_done_timeout", v, 32'hffff_ffff);
        break;
      end
      e.bcd = dec_model(v, 3); e.ovf = 1'b0; e.acc = cyc + 1;
      start0 = 1'b1; bin0 = 8'(v); q0.push_back(e);
      @(negedge clk);
      start0 = 1'b0;
    end
    drain(0);
    chk("sweep_done_count", dones0 - base, 32'd256);

    // Start while busy is ignored
    base = dones0;
    issue(0, 16'd37, 20'h037, 1'b0);
    repeat (2) @(negedge clk);
    start0 = 1'b1; bin0 = 8'd200;
    @(negedge clk);
    start0 = 1'b0;
    drain(0);
    repeat (12) @(negedge clk);
    chk("busy_start_dropped", dones0 - base, 32'd1);
    chk("held_bcd_37", {20'd0, bcd0}, 32'h037);

    // Reset mid-conversion aborts without a done pulse
    base = dones0;
    issue(0, 16'd123, 20'h123, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    chk("abort_bcd",  {20'd0, bcd0},  32'd0);
    chk("abort_ovf",  {31'd0, ovf0},  32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", dones0 - base, 32'd0);
    issue(0, 16'd123, 20'h123, 1'b0); drain(0);

    // Two digits: overflow keeps the low digits
    issue(1, 16'd99,  20'h99, 1'b0); drain(1);
    issue(1, 16'd100, 20'h00, 1'b1); drain(1);
    issue(1, 16'd255, 20'h55, 1'b1); drain(1);

    // Sixteen bits, five digits
    issue(2, 16'd65535, 20'h65535, 1'b0); drain(2);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
